issue_scoreboard: RTL and testbench

//  Register scoreboard and issue gate between the decode phase and the execute stage.
//  - Tracks GPRs and FPRs with a pending write from long-latency ops (loads, FPU ops).
//  - Holds a decoded instruction (stall) while any register it reads or writes is pending.
//  - Sits after decode; consumes decode's d/s/t from/to GPR/FPR flags and register addresses.

---
 rtl/issue_scoreboard_if.sv | 49 ++++
 rtl/issue_scoreboard.sv | 82 ++++++++
 tb/tb_issue_scoreboard.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode/execute/write-back signal bundle for the issue scoreboard.
// master: the decode/execute/write-back side; slave: the scoreboard.
interface issue_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  dec_valid;
  logic                  dec_ready;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic                  d_from_gpr;
  logic                  d_from_fpr;
  logic                  d_to_gpr;
  logic                  d_to_fpr;
  logic                  s_from_gpr;
  logic                  s_from_fpr;
  logic                  t_from_gpr;
  logic                  t_from_fpr;
  logic                  dec_long;
  logic                  ex_ready;
  logic                  issue_valid;
  logic                  wb_gpr_valid;
  logic [REG_ADDR_W-1:0] wb_gpr_addr;
  logic                  wb_fpr_valid;
  logic [REG_ADDR_W-1:0] wb_fpr_addr;
  logic [NUM_REGS-1:0]   gpr_busy;
  logic [NUM_REGS-1:0]   fpr_busy;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output dec_valid, rd_addr, rs_addr, rt_addr,
    output d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr,
    output s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr,
    output dec_long, ex_ready,
    output wb_gpr_valid, wb_gpr_addr, wb_fpr_valid, wb_fpr_addr,
    input  dec_ready, issue_valid, gpr_busy, fpr_busy, stall_cycles
  );

  modport slave (
    input  dec_valid, rd_addr, rs_addr, rt_addr,
    input  d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr,
    input  s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr,
    input  dec_long, ex_ready,
    input  wb_gpr_valid, wb_gpr_addr, wb_fpr_valid, wb_fpr_addr,
    output dec_ready, issue_valid, gpr_busy, fpr_busy, stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate between decode and execute.
// Tracks GPR/FPR registers awaiting a long-latency write-back and holds a
// decoded instruction while any register it touches is still pending.
module issue_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rstn,
  issue_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0]   gpr_busy_q, gpr_busy_d;
  logic [NUM_REGS-1:0]   fpr_busy_q, fpr_busy_d;
  logic [NUM_REGS-1:0]   gpr_set, gpr_clr, fpr_set, fpr_clr;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic [REG_ADDR_W-1:0] rd_a, rs_a, rt_a, wbg_a, wbf_a;
  logic                  gpr_hazard, fpr_hazard, hazard, fire;

  assign rd_a  = sb.rd_addr;
  assign rs_a  = sb.rs_addr;
  assign rt_a  = sb.rt_addr;
  assign wbg_a = sb.wb_gpr_addr;
  assign wbf_a = sb.wb_fpr_addr;

  // Hazard looks only at registered busy bits, so a same-cycle write-back
  // never bypasses; the dependant issues one cycle after the write-back.
  always_comb begin
    gpr_hazard = ((sb.d_from_gpr | sb.d_to_gpr) & gpr_busy_q[rd_a])
               | (sb.s_from_gpr & gpr_busy_q[rs_a])
               | (sb.t_from_gpr & gpr_busy_q[rt_a]);
    fpr_hazard = ((sb.d_from_fpr | sb.d_to_fpr) & fpr_busy_q[rd_a])
               | (sb.s_from_fpr & fpr_busy_q[rs_a])
               | (sb.t_from_fpr & fpr_busy_q[rt_a]);
    hazard     = gpr_hazard | fpr_hazard;
  end

  assign fire           = sb.dec_valid & ~hazard & sb.ex_ready;
  assign sb.dec_ready   = ~hazard & sb.ex_ready;
  assign sb.issue_valid = sb.dec_valid & ~hazard;

  // Busy next-state: write-back clears, a long op issuing sets; set wins.
  // GPR 0 is hard-wired to never be pending.
  always_comb begin
    gpr_set = '0;
    fpr_set = '0;
    gpr_clr = '0;
    fpr_clr = '0;
    if (fire & sb.dec_long & sb.d_to_gpr) gpr_set[rd_a] = 1'b1;
    if (fire & sb.dec_long & sb.d_to_fpr) fpr_set[rd_a] = 1'b1;
    if (sb.wb_gpr_valid) gpr_clr[wbg_a] = 1'b1;
    if (sb.wb_fpr_valid) fpr_clr[wbf_a] = 1'b1;
    gpr_busy_d    = (gpr_busy_q & ~gpr_clr) | gpr_set;
    fpr_busy_d    = (fpr_busy_q & ~fpr_clr) | fpr_set;
    gpr_busy_d[0] = 1'b0;
  end

  // Hazard stall counter; ex_ready back-pressure alone is not counted.
  always_comb begin
    stall_d = stall_q;
    if (sb.dec_valid & hazard & ~(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gpr_busy_q <= '0;
      fpr_busy_q <= '0;
      stall_q    <= '0;
    end else begin
      gpr_busy_q <= gpr_busy_d;
      fpr_busy_q <= fpr_busy_d;
      stall_q    <= stall_d;
    end
  end

  assign sb.gpr_busy     = gpr_busy_q;
  assign sb.fpr_busy     = fpr_busy_q;
  assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus a
// randomized run against a pending-register reference model.
module tb_issue_scoreboard;

  logic clk;
  logic rstn;
  int   passed;
  int   total;

  typedef struct {
    bit fpr;
    int addr;
  } use_t;

  issue_scoreboard_if #(.NUM_REGS(32), .REG_ADDR_W(5), .CNT_W(32)) sbif ();

  issue_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .sb   (sbif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sbif.dec_valid    = 1'b0;
    sbif.rd_addr      = '0;
    sbif.rs_addr      = '0;
    sbif.rt_addr      = '0;
    sbif.d_from_gpr   = 1'b0;
    sbif.d_from_fpr   = 1'b0;
    sbif.d_to_gpr     = 1'b0;
    sbif.d_to_fpr     = 1'b0;
    sbif.s_from_gpr   = 1'b0;
    sbif.s_from_fpr   = 1'b0;
    sbif.t_from_gpr   = 1'b0;
    sbif.t_from_fpr   = 1'b0;
    sbif.dec_long     = 1'b0;
    sbif.ex_ready     = 1'b1;
    sbif.wb_gpr_valid = 1'b0;
    sbif.wb_gpr_addr  = '0;
    sbif.wb_fpr_valid = 1'b0;
    sbif.wb_fpr_addr  = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) tick();
    total++; if (sbif.gpr_busy !== 32'h0) $display("FAIL reset_gpr_busy: got %h want 0", sbif.gpr_busy); else passed++;
    total++; if (sbif.fpr_busy !== 32'h0) $display("FAIL reset_fpr_busy: got %h want 0", sbif.fpr_busy); else passed++;
    total++; if (sbif.stall_cycles !== 32'h0) $display("FAIL reset_stall: got %0d want 0", sbif.stall_cycles); else passed++;
    total++; if (sbif.dec_ready !== 1'b1) $display("FAIL reset_ready_hi: got %b want 1", sbif.dec_ready); else passed++;
    sbif.ex_ready = 1'b0;
    #1;
    total++; if (sbif.dec_ready !== 1'b0) $display("FAIL reset_ready_lo: got %b want 0", sbif.dec_ready); else passed++;
    sbif.ex_ready = 1'b1;
  endtask

  // Long load to GPR5, dependent reader stalls 4 cycles, issues after write-back.
  task automatic test_raw_load();
    apply_reset();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd5;
    #1;
    total++; if (sbif.issue_valid !== 1'b1) $display("FAIL raw_load_issue: got %b want 1", sbif.issue_valid); else passed++;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.s_from_gpr = 1'b1; sbif.rs_addr = 5'd5;
    sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd9;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        sbif.wb_gpr_valid = 1'b1; sbif.wb_gpr_addr = 5'd5;
      end
      #1;
      total++; if (sbif.issue_valid !== 1'b0) $display("FAIL raw_stall_T+%0d: got %b want 0", k, sbif.issue_valid); else passed++;
      if (k == 1) begin
        total++; if (sbif.gpr_busy !== 32'h20) $display("FAIL raw_busy: got %h want 20", sbif.gpr_busy); else passed++;
      end
      tick();
    end
    sbif.wb_gpr_valid = 1'b0;
    #1;
    total++; if (sbif.issue_valid !== 1'b1) $display("FAIL raw_issue_T+5: got %b want 1", sbif.issue_valid); else passed++;
    total++; if (sbif.stall_cycles !== 32'd4) $display("FAIL raw_stall_count: got %0d want 4", sbif.stall_cycles); else passed++;
    total++; if (sbif.gpr_busy !== 32'h0) $display("FAIL raw_cleared: got %h want 0", sbif.gpr_busy); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (sbif.gpr_busy !== 32'h0) $display("FAIL raw_short_no_set: got %h want 0", sbif.gpr_busy); else passed++;
  endtask

  // Long FPU op to FPR3, WAW on FPR3 stalls until write-back + 1; GPR3 unaffected.
  task automatic test_waw_fpr();
    apply_reset();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_fpr = 1'b1; sbif.rd_addr = 5'd3;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.d_from_gpr = 1'b1; sbif.s_from_gpr = 1'b1;
    sbif.rd_addr = 5'd3; sbif.rs_addr = 5'd3;
    #1;
    total++; if (sbif.issue_valid !== 1'b1) $display("FAIL waw_gpr3_free: got %b want 1", sbif.issue_valid); else passed++;
    total++; if (sbif.fpr_busy !== 32'h8) $display("FAIL waw_fpr_busy: got %h want 8", sbif.fpr_busy); else passed++;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.d_to_fpr = 1'b1; sbif.rd_addr = 5'd3;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        sbif.wb_fpr_valid = 1'b1; sbif.wb_fpr_addr = 5'd3;
      end
      #1;
      total++; if (sbif.issue_valid !== 1'b0) $display("FAIL waw_stall_%0d: got %b want 0", k, sbif.issue_valid); else passed++;
      tick();
    end
    sbif.wb_fpr_valid = 1'b0;
    #1;
    total++; if (sbif.issue_valid !== 1'b1) $display("FAIL waw_issue: got %b want 1", sbif.issue_valid); else passed++;
    total++; if (sbif.stall_cycles !== 32'd3) $display("FAIL waw_stall_count: got %0d want 3", sbif.stall_cycles); else passed++;
    tick();
    clear_inputs();
  endtask

  // GPR0 never goes busy; FPR0 is an ordinary register; set beats clear.
  task automatic test_reg_zero();
    apply_reset();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd0;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.s_from_gpr = 1'b1; sbif.t_from_gpr = 1'b1; sbif.d_from_gpr = 1'b1;
    #1;
    total++; if (sbif.gpr_busy !== 32'h0) $display("FAIL gpr0_busy: got %h want 0", sbif.gpr_busy); else passed++;
    total++; if (sbif.issue_valid !== 1'b1) $display("FAIL gpr0_reader: got %b want 1", sbif.issue_valid); else passed++;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_fpr = 1'b1; sbif.rd_addr = 5'd0;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.s_from_fpr = 1'b1; sbif.rs_addr = 5'd0;
    #1;
    total++; if (sbif.fpr_busy !== 32'h1) $display("FAIL fpr0_busy: got %h want 1", sbif.fpr_busy); else passed++;
    total++; if (sbif.issue_valid !== 1'b0) $display("FAIL fpr0_reader: got %b want 0", sbif.issue_valid); else passed++;
    clear_inputs();
    sbif.wb_fpr_valid = 1'b1; sbif.wb_fpr_addr = 5'd0;
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd10;
    sbif.wb_gpr_valid = 1'b1; sbif.wb_gpr_addr = 5'd10;
    tick();
    clear_inputs();
    #1;
    total++; if (sbif.gpr_busy !== 32'h400) $display("FAIL set_wins: got %h want 400", sbif.gpr_busy); else passed++;
    total++; if (sbif.fpr_busy !== 32'h0) $display("FAIL fpr0_cleared: got %h want 0", sbif.fpr_busy); else passed++;
  endtask

  // ex_ready low without a hazard: no fire, no stall count.
  task automatic test_ex_backpressure();
    apply_reset();
    sbif.dec_valid = 1'b1; sbif.s_from_gpr = 1'b1; sbif.rs_addr = 5'd4;
    sbif.dec_long = 1'b1; sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd6; sbif.ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (sbif.dec_ready !== 1'b0 || sbif.issue_valid !== 1'b1)
        $display("FAIL bp_cycle_%0d: got ready=%b issue=%b want ready=0 issue=1", k, sbif.dec_ready, sbif.issue_valid);
      else passed++;
      tick();
    end
    total++; if (sbif.gpr_busy !== 32'h0) $display("FAIL bp_no_set: got %h want 0", sbif.gpr_busy); else passed++;
    total++; if (sbif.stall_cycles !== 32'd0) $display("FAIL bp_no_count: got %0d want 0", sbif.stall_cycles); else passed++;
    sbif.ex_ready = 1'b1;
    #1;
    total++; if (sbif.dec_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", sbif.dec_ready); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (sbif.gpr_busy !== 32'h40) $display("FAIL bp_fired: got %h want 40", sbif.gpr_busy); else passed++;
  endtask

  // Reset mid-operation drops all pending writes and the counter.
  task automatic test_reset_mid();
    apply_reset();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_gpr = 1'b1; sbif.rd_addr = 5'd7;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.dec_long = 1'b1; sbif.d_to_fpr = 1'b1; sbif.rd_addr = 5'd7;
    tick();
    clear_inputs();
    sbif.dec_valid = 1'b1; sbif.s_from_gpr = 1'b1; sbif.rs_addr = 5'd7;
    sbif.t_from_fpr = 1'b1; sbif.rt_addr = 5'd7;
    #1;
    total++; if (sbif.gpr_busy !== 32'h80 || sbif.fpr_busy !== 32'h80)
      $display("FAIL mid_busy: got gpr=%h fpr=%h want 80/80", sbif.gpr_busy, sbif.fpr_busy);
    else passed++;
    total++; if (sbif.issue_valid !== 1'b0) $display("FAIL mid_stalled: got %b want 0", sbif.issue_valid); else passed++;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    total++; if (sbif.gpr_busy !== 32'h0 || sbif.fpr_busy !== 32'h0)
      $display("FAIL mid_reset_busy: got gpr=%h fpr=%h want 0/0", sbif.gpr_busy, sbif.fpr_busy);
    else passed++;
    total++; if (sbif.stall_cycles !== 32'd0) $display("FAIL mid_reset_count: got %0d want 0", sbif.stall_cycles); else passed++;
    total++; if (sbif.issue_valid !== 1'b1 || sbif.dec_ready !== 1'b1)
      $display("FAIL mid_reissue: got issue=%b ready=%b want 1/1", sbif.issue_valid, sbif.dec_ready);
    else passed++;
    tick();
    clear_inputs();
  endtask

  // Randomized traffic against a pending-register model.
  task automatic test_random();
    bit          gp[32];
    bit          fp[32];
    int unsigned ms;
    use_t        uses[$];
    bit          haz, fire;
    bit          v, lng, exr, dfg, dff, dtg, dtf, sfg, sff, tfg, tff, wgv, wfv;
    int          rd, rs, rt, wga, wfa;
    logic [31:0] eg, ef;
    apply_reset();
    foreach (gp[i]) begin
      gp[i] = 1'b0;
      fp[i] = 1'b0;
    end
    ms = 0;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      lng = $urandom_range(0, 1) == 1;
      exr = $urandom_range(0, 4) != 0;
      dfg = $urandom_range(0, 3) == 0; dff = $urandom_range(0, 3) == 0;
      dtg = $urandom_range(0, 2) == 0; dtf = $urandom_range(0, 2) == 0;
      sfg = $urandom_range(0, 1) == 1; sff = $urandom_range(0, 2) == 0;
      tfg = $urandom_range(0, 2) == 0; tff = $urandom_range(0, 2) == 0;
      wgv = $urandom_range(0, 3) == 0; wfv = $urandom_range(0, 3) == 0;
      rd  = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
      wga = $urandom_range(0, 7); wfa = $urandom_range(0, 7);
      sbif.dec_valid = v; sbif.dec_long = lng; sbif.ex_ready = exr;
      sbif.d_from_gpr = dfg; sbif.d_from_fpr = dff; sbif.d_to_gpr = dtg; sbif.d_to_fpr = dtf;
      sbif.s_from_gpr = sfg; sbif.s_from_fpr = sff; sbif.t_from_gpr = tfg; sbif.t_from_fpr = tff;
      sbif.rd_addr = 5'(rd); sbif.rs_addr = 5'(rs); sbif.rt_addr = 5'(rt);
      sbif.wb_gpr_valid = wgv; sbif.wb_gpr_addr = 5'(wga);
      sbif.wb_fpr_valid = wfv; sbif.wb_fpr_addr = 5'(wfa);

      uses.delete();
      if (dfg || dtg) uses.push_back('{1'b0, rd});
      if (dff || dtf) uses.push_back('{1'b1, rd});
      if (sfg) uses.push_back('{1'b0, rs});
      if (sff) uses.push_back('{1'b1, rs});
      if (tfg) uses.push_back('{1'b0, rt});
      if (tff) uses.push_back('{1'b1, rt});
      haz = 1'b0;
      foreach (uses[i]) begin
        if (uses[i].fpr ? fp[uses[i].addr] : gp[uses[i].addr]) haz = 1'b1;
      end
      for (int i = 0; i < 32; i++) begin
        eg[i] = gp[i];
        ef[i] = fp[i];
      end

      #1;
      total++; if (sbif.dec_ready !== (!haz && exr)) $display("FAIL rnd_ready_c%0d: got %b want %b", c, sbif.dec_ready, (!haz && exr)); else passed++;
      total++; if (sbif.issue_valid !== (v && !haz)) $display("FAIL rnd_issue_c%0d: got %b want %b", c, sbif.issue_valid, (v && !haz)); else passed++;
      total++; if (sbif.gpr_busy !== eg) $display("FAIL rnd_gpr_busy_c%0d: got %h want %h", c, sbif.gpr_busy, eg); else passed++;
      total++; if (sbif.fpr_busy !== ef) $display("FAIL rnd_fpr_busy_c%0d: got %h want %h", c, sbif.fpr_busy, ef); else passed++;
      total++; if (sbif.stall_cycles !== ms) $display("FAIL rnd_stall_c%0d: got %0d want %0d", c, sbif.stall_cycles, ms); else passed++;

      fire = v && !haz && exr;
      if (wgv) gp[wga] = 1'b0;
      if (wfv) fp[wfa] = 1'b0;
      if (fire && lng && dtg && rd != 0) gp[rd] = 1'b1;
      if (fire && lng && dtf) fp[rd] = 1'b1;
      if (v && haz && ms != 32'hFFFF_FFFF) ms++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clk    = 1'b0;
    rstn   = 1'b0;
    passed = 0;
    total  = 0;
    clear_inputs();
    test_reset();
    test_raw_load();
    test_waw_fpr();
    test_reg_zero();
    test_ex_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
